// File: rtl/ram_arbiter.sv
// Arbitrates the single-port unified RAM between instruction fetch and data access.
// Data has priority; a streak limit bounds fetch starvation and a watchdog traps a stalled RAM.
module ram_arbiter #(
  parameter int WORD_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 64
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  input  logic              halt,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              halted,
  output logic              err
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW-1:0] SMAX = SW'(MAX_DSTREAK);
  localparam logic [WW-1:0] WLIM = WW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_IACC,
    S_DACC,
    S_HALTED,
    S_ERROR
  } state_t;

  state_t            state_q;
  logic [WORD_W-1:0] addr_q, store_q, iload_q, dload_q;
  logic              ren_q, wen_q;
  logic [SW-1:0]     streak_q, streak_d;
  logic [WW-1:0]     wdog_q;
  logic              data_req, force_i, wd_expire, idone, ddone;

  always_comb begin
    data_req  = dREN | dWEN;
    force_i   = iREN && (streak_q == SMAX);
    streak_d  = (streak_q == SMAX) ? streak_q : streak_q + 1'b1;
    wd_expire = (TIMEOUT != 0) && (wdog_q == WLIM) && !ram_ready;
    idone     = (state_q == S_IACC) && ram_ready;
    ddone     = (state_q == S_DACC) && ram_ready;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      store_q  <= '0;
      iload_q  <= '0;
      dload_q  <= '0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      streak_q <= '0;
      wdog_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!iREN) streak_q <= '0;
          if (data_req && !force_i) begin
            state_q  <= S_DACC;
            addr_q   <= daddr;
            store_q  <= dstore;
            wen_q    <= dWEN;
            ren_q    <= !dWEN;
            wdog_q   <= '0;
            streak_q <= iREN ? streak_d : '0;
          end else if (data_req || (!halt && iREN)) begin
            // A data request reaching here was pre-empted by the streak limit, so iREN is high.
            state_q  <= S_IACC;
            addr_q   <= iaddr;
            ren_q    <= 1'b1;
            wen_q    <= 1'b0;
            wdog_q   <= '0;
            streak_q <= '0;
          end else if (halt) begin
            state_q <= S_HALTED;
          end
        end
        S_IACC, S_DACC: begin
          if (ram_ready) begin
            state_q <= S_IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            if (state_q == S_IACC) iload_q <= ramload;
            else                   dload_q <= ramload;
          end else if (wd_expire) begin
            state_q <= S_ERROR;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        default: state_q <= state_q;
      endcase
    end
  end

  assign ramREN   = ren_q;
  assign ramWEN   = wen_q;
  assign ramaddr  = addr_q;
  assign ramstore = store_q;
  assign iwait    = !idone;
  assign dwait    = !ddone;
  assign iload    = idone ? ramload : iload_q;
  assign dload    = ddone ? ramload : dload_q;
  assign halted   = (state_q == S_HALTED);
  assign err      = (state_q == S_ERROR);

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: fetch, data priority, streak limit, watchdog, halt and async reset.
module tb_ram_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN, dREN, dWEN, halt, ram_ready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic        iwait, dwait, ramREN, ramWEN, halted, err;
  logic [31:0] iload, dload, ramaddr, ramstore;

  int checks = 0;
  int errors = 0;

  ram_arbiter #(.WORD_W(32), .MAX_DSTREAK(4), .TIMEOUT(8)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .halt(halt),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .halted(halted), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    #2;
    RST = 1'b0;
    #1;
  endtask

  initial begin
    RST = 1'b1;
    {iREN, dREN, dWEN, halt, ram_ready} = '0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    #12;
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_iwait", 32'(iwait), 32'd1);
    check("rst_dwait", 32'(dwait), 32'd1);
    check("rst_iload", iload, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    RST = 1'b0;

    // 1: single instruction fetch
    iREN = 1'b1; iaddr = 32'h40;
    tick();
    check("t1_ramREN", 32'(ramREN), 32'd1);
    check("t1_ramaddr", ramaddr, 32'h40);
    check("t1_iwait_busy", 32'(iwait), 32'd1);
    ram_ready = 1'b1; ramload = 32'hA5A5_0001; #1;
    check("t1_iwait_done", 32'(iwait), 32'd0);
    check("t1_iload", iload, 32'hA5A5_0001);
    tick();
    iREN = 1'b0; ram_ready = 1'b0; ramload = 32'h0; #1;
    check("t1_idle_ramREN", 32'(ramREN), 32'd0);
    check("t1_idle_iwait", 32'(iwait), 32'd1);
    check("t1_iload_hold", iload, 32'hA5A5_0001);

    // 2: simultaneous write and fetch, write first, one bubble
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEAD_BEEF;
    tick();
    check("t2_ramWEN", 32'(ramWEN), 32'd1);
    check("t2_ramREN", 32'(ramREN), 32'd0);
    check("t2_ramaddr", ramaddr, 32'h100);
    check("t2_ramstore", ramstore, 32'hDEAD_BEEF);
    ram_ready = 1'b1; #1;
    check("t2_dwait_done", 32'(dwait), 32'd0);
    check("t2_iwait_busy", 32'(iwait), 32'd1);
    tick();
    dWEN = 1'b0; ram_ready = 1'b0; #1;
    check("t2_bubble_strobes", 32'({ramREN, ramWEN}), 32'd0);
    tick();
    check("t2_i_ramREN", 32'(ramREN), 32'd1);
    check("t2_i_ramaddr", ramaddr, 32'h44);
    ram_ready = 1'b1; ramload = 32'h1111_2222; #1;
    check("t2_iload", iload, 32'h1111_2222);
    tick();
    iREN = 1'b0; ram_ready = 1'b0; #1;

    // 3: data streak limit with fetch pending
    dREN = 1'b1; daddr = 32'h200; iREN = 1'b1; iaddr = 32'h48;
    for (int g = 0; g < 6; g++) begin
      tick();
      check($sformatf("t3_g%0d_addr", g), ramaddr, (g == 4) ? 32'h48 : 32'h200);
      check($sformatf("t3_g%0d_ramREN", g), 32'(ramREN), 32'd1);
      ram_ready = 1'b1; ramload = 32'h300 + 32'(g); #1;
      if (g == 4) check($sformatf("t3_g%0d_iwait", g), 32'(iwait), 32'd0);
      else        check($sformatf("t3_g%0d_dload", g), dload, 32'h300 + 32'(g));
      tick();
      ram_ready = 1'b0; #1;
    end
    dREN = 1'b0; iREN = 1'b0;
    tick();

    // 4: watchdog expiry on a stuck data read
    dREN = 1'b1; daddr = 32'h300;
    tick();
    for (int c = 0; c < 7; c++) begin
      tick();
      check($sformatf("t4_c%0d_err", c), 32'(err), 32'd0);
    end
    check("t4_pre_ramREN", 32'(ramREN), 32'd1);
    tick();
    check("t4_err", 32'(err), 32'd1);
    check("t4_strobes", 32'({ramREN, ramWEN}), 32'd0);
    check("t4_dwait", 32'(dwait), 32'd1);
    ram_ready = 1'b1; #1;
    check("t4_dwait_ready", 32'(dwait), 32'd1);
    tick(); tick();
    check("t4_err_sticky", 32'(err), 32'd1);
    check("t4_iwait", 32'(iwait), 32'd1);
    dREN = 1'b0; ram_ready = 1'b0;
    pulse_reset();
    check("t4_err_cleared", 32'(err), 32'd0);

    // 5: halt during a data access
    iREN = 1'b1; iaddr = 32'h50; dREN = 1'b1; daddr = 32'h400;
    tick();
    check("t5_ramaddr", ramaddr, 32'h400);
    halt = 1'b1; ram_ready = 1'b1; ramload = 32'hCAFE_0005; #1;
    check("t5_dwait", 32'(dwait), 32'd0);
    check("t5_dload", dload, 32'hCAFE_0005);
    tick();
    dREN = 1'b0; ram_ready = 1'b0; #1;
    tick();
    check("t5_halted", 32'(halted), 32'd1);
    check("t5_ramREN", 32'(ramREN), 32'd0);
    check("t5_iwait", 32'(iwait), 32'd1);
    halt = 1'b0; dREN = 1'b1;
    tick(); tick();
    check("t5_ignored", 32'({ramREN, ramWEN, halted}), 32'b001);
    dREN = 1'b0; iREN = 1'b0;
    pulse_reset();
    check("t5_halted_cleared", 32'(halted), 32'd0);

    // 6: asynchronous reset in the middle of a fetch
    iREN = 1'b1; iaddr = 32'h60;
    tick();
    check("t6_ramREN", 32'(ramREN), 32'd1);
    #2;
    RST = 1'b1; #1;
    check("t6_async_ramREN", 32'(ramREN), 32'd0);
    check("t6_async_iwait", 32'(iwait), 32'd1);
    check("t6_async_ramaddr", ramaddr, 32'd0);
    RST = 1'b0;
    tick();
    check("t6_regrant_ramREN", 32'(ramREN), 32'd1);
    check("t6_regrant_addr", ramaddr, 32'h60);
    ram_ready = 1'b1; ramload = 32'h0BAD_F00D; #1;
    check("t6_iwait", 32'(iwait), 32'd0);
    check("t6_iload", iload, 32'h0BAD_F00D);
    tick();
    iREN = 1'b0; ram_ready = 1'b0; #1;
    check("t6_idle", 32'(ramREN), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
